// File: rtl/ieee488_sd_pkg.sv
// ============================================================================
// ieee488_sd_pkg : shared types/constants for the IEEE-488 SD arbiter slice
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package ieee488_sd_pkg;

  localparam int LBA_W  = 32;
  localparam int BLK_W  = 6;
  localparam int TOUT_W = 24;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    XFER = 3'd2,
    GAP  = 3'd3,
    TOUT = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] scanning upward from ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr,
                                       input int n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        j = 32'(ptr) + k;
        if (j >= n) j = j - n;
        if (!r.valid && req[j[1:0]]) begin
          r.valid = 1'b1;
          r.idx   = j[1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ieee488_sd_arbiter_if.sv
// ============================================================================
// ieee488_sd_arbiter_if : drive-side and host-side SD bus of the arbiter
// Optional tout_err member under IEEE488_SD_ARB_TIMEOUT_EN. Rev 1.0
// ============================================================================
`default_nettype none

interface ieee488_sd_arbiter_if #(parameter int NDR = 2);

  logic [NDR-1:0][31:0] drv_lba;
  logic [NDR-1:0][5:0]  drv_blk_cnt;
  logic [NDR-1:0]       drv_rd;
  logic [NDR-1:0]       drv_wr;
  logic [NDR-1:0]       drv_ack;
  logic [NDR-1:0][7:0]  drv_buff_din;
  logic [31:0]          sd_lba;
  logic [5:0]           sd_blk_cnt;
  logic                 sd_rd;
  logic                 sd_wr;
  logic                 sd_ack;
  logic [7:0]           sd_buff_din;
  logic [1:0]           sd_dev;
  logic                 busy;
`ifdef IEEE488_SD_ARB_TIMEOUT_EN
  logic                 tout_err;
`endif

  // master: the arbiter itself; slave: drives + host around it
  modport master (
`ifdef IEEE488_SD_ARB_TIMEOUT_EN
    output tout_err,
`endif
    input  drv_lba, drv_blk_cnt, drv_rd, drv_wr, drv_buff_din, sd_ack,
    output drv_ack, sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din, sd_dev, busy
  );

  modport slave (
`ifdef IEEE488_SD_ARB_TIMEOUT_EN
    input  tout_err,
`endif
    output drv_lba, drv_blk_cnt, drv_rd, drv_wr, drv_buff_din, sd_ack,
    input  drv_ack, sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din, sd_dev, busy
  );

endinterface

`default_nettype wire

// File: rtl/ieee488_rr_pick.sv
// ============================================================================
// ieee488_rr_pick : combinational round-robin priority selector (up to 4 req)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module ieee488_rr_pick
  import ieee488_sd_pkg::*;
#(
  parameter int NDR = 2
) (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] idx_o,
  output logic       vld_o
);

  rr_pick_t pick_w;

  assign pick_w = rr_pick(req_i, ptr_i, NDR);
  assign idx_o  = pick_w.idx;
  assign vld_o  = pick_w.valid;

endmodule

`default_nettype wire

// File: rtl/ieee488_sd_arbiter.sv
// ============================================================================
// ieee488_sd_arbiter : round-robin share of one host SD port among NDR drives
// Optional watchdog/TOUT state under IEEE488_SD_ARB_TIMEOUT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module ieee488_sd_arbiter
  import ieee488_sd_pkg::*;
#(
  parameter int NDR = 2
`ifdef IEEE488_SD_ARB_TIMEOUT_EN
  , parameter logic [TOUT_W-1:0] TOUT_LIMIT = '1
`endif
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  ieee488_sd_arbiter_if.master   bus
);

  localparam int N = NDR - 1;

  arb_state_t       state_q;
  logic [1:0]       rr_q;
  logic [1:0]       grant_q;
  logic [LBA_W-1:0] lba_q;
  logic [BLK_W-1:0] cnt_q;
  logic             sd_rd_q;
  logic             sd_wr_q;

  logic [3:0]       req4_w;
  logic [1:0]       pick_idx_w;
  logic             pick_vld_w;
  logic             g_req_w;
  logic [7:0]       g_din_w;
  logic [LBA_W-1:0] p_lba_w;
  logic [BLK_W-1:0] p_cnt_w;
  logic             p_rd_w;
  logic             ack_phase_w;
  logic [1:0]       rr_next_w;
  logic             tout_w;

`ifdef IEEE488_SD_ARB_TIMEOUT_EN
  logic [TOUT_W-1:0] wd_q;
  logic              tout_err_q;
  assign tout_w       = (wd_q == TOUT_LIMIT);
  assign bus.tout_err = tout_err_q;
`else
  assign tout_w = 1'b0;
`endif

  always_comb begin
    req4_w  = '0;
    g_req_w = 1'b0;
    g_din_w = '0;
    p_lba_w = '0;
    p_cnt_w = '0;
    p_rd_w  = 1'b0;
    for (int i = 0; i <= N; i++) begin
      req4_w[i] = bus.drv_rd[i] | bus.drv_wr[i];
      if (grant_q == 2'(i)) begin
        g_req_w = bus.drv_rd[i] | bus.drv_wr[i];
        g_din_w = bus.drv_buff_din[i];
      end
      if (pick_idx_w == 2'(i)) begin
        p_lba_w = bus.drv_lba[i];
        p_cnt_w = bus.drv_blk_cnt[i];
        p_rd_w  = bus.drv_rd[i];
      end
    end
  end

  ieee488_rr_pick #(.NDR(NDR)) u_pick (
    .req_i (req4_w),
    .ptr_i (rr_q),
    .idx_o (pick_idx_w),
    .vld_o (pick_vld_w)
  );

  assign rr_next_w   = (grant_q == 2'(N)) ? 2'd0 : grant_q + 2'd1;
  // Ack passes through from the first sd_ack cycle in REQ so the drive sees it for the whole transfer.
  assign ack_phase_w = (state_q == REQ) || (state_q == XFER);

  always_comb begin
    bus.drv_ack = '0;
    for (int i = 0; i <= N; i++) begin
      bus.drv_ack[i] = ack_phase_w && bus.sd_ack && (grant_q == 2'(i));
    end
  end

  assign bus.sd_buff_din = g_din_w;
  assign bus.sd_lba      = lba_q;
  assign bus.sd_blk_cnt  = cnt_q;
  assign bus.sd_rd       = sd_rd_q;
  assign bus.sd_wr       = sd_wr_q;
  assign bus.sd_dev      = grant_q;
  assign bus.busy        = (state_q != IDLE);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      lba_q   <= '0;
      cnt_q   <= '0;
      sd_rd_q <= 1'b0;
      sd_wr_q <= 1'b0;
`ifdef IEEE488_SD_ARB_TIMEOUT_EN
      wd_q       <= '0;
      tout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld_w) begin
            grant_q <= pick_idx_w;
            lba_q   <= p_lba_w;
            cnt_q   <= p_cnt_w;
            sd_rd_q <= p_rd_w;
            sd_wr_q <= ~p_rd_w;
            state_q <= REQ;
`ifdef IEEE488_SD_ARB_TIMEOUT_EN
            wd_q    <= '0;
`endif
          end
        end
        REQ, XFER: begin
          if (tout_w) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            rr_q    <= rr_next_w;
            state_q <= TOUT;
`ifdef IEEE488_SD_ARB_TIMEOUT_EN
            tout_err_q <= 1'b1;
`endif
          end else begin
`ifdef IEEE488_SD_ARB_TIMEOUT_EN
            wd_q <= wd_q + 1'b1;
`endif
            if (state_q == REQ) begin
              if (bus.sd_ack) begin
                sd_rd_q <= 1'b0;
                sd_wr_q <= 1'b0;
                state_q <= XFER;
              end else if (!g_req_w) begin
                sd_rd_q <= 1'b0;
                sd_wr_q <= 1'b0;
                state_q <= GAP;
              end
            end else if (!bus.sd_ack) begin
              rr_q    <= rr_next_w;
              state_q <= GAP;
            end
          end
        end
        TOUT:    state_q <= GAP;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
